// File: rtl/jt10_adpcmb_pkg.sv
// jt10_adpcmb_pkg: shared width default and interpolator state encoding
package jt10_adpcmb_pkg;
  localparam int dw_default = 16;
  typedef enum logic [2:0] {IDLE, START, SKIP, WAIT, RUN} state_t;
endpackage

// File: rtl/jt10_adpcmb_erracc.sv
// jt10_adpcmb_erracc: accumulates the divide remainder and raises extra once per full period
module jt10_adpcmb_erracc
  import jt10_adpcmb_pkg::*;
#(
  parameter int dw = dw_default
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [dw-1:0] rem,
  input  logic [dw-1:0] peff,
  input  logic          clr,
  input  logic          adv,
  output logic          extra
);
  logic [dw-1:0] err;
  logic [dw:0] e;
  // carry when the accumulated remainder reaches a whole period
  always_comb begin
    e = {1'b0, err} + {1'b0, rem};
    extra = e >= {1'b0, peff};
  end
  // err stays below peff, so the low dw bits of e - peff are exact
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= '0;
    else if (cen) err <= clr ? '0 : adv ? (extra ? e[dw-1:0] - peff : e[dw-1:0]) : err;
endmodule

// File: rtl/jt10_adpcmb_interp.sv
// jt10_adpcmb_interp: linear ramp between ADPCM-B samples; JT10_ADPCMB_INTERP_EN enables it, otherwise zero-order hold
module jt10_adpcmb_interp
  import jt10_adpcmb_pkg::*;
#(
  parameter int dw = dw_default
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [dw-1:0] sample_in,
  input  logic          sample_stb,
  input  logic [dw-1:0] period,
  output logic          div_start,
  output logic [dw-1:0] div_a,
  output logic [dw-1:0] div_b,
  input  logic [dw-1:0] div_d,
  input  logic [dw-1:0] div_r,
  input  logic          div_working,
  output logic [dw-1:0] sample_out,
  output logic          busy
);
`ifdef JT10_ADPCMB_INTERP_EN
  state_t state, next;
  logic neg, extra;
  logic [dw-1:0] peff, step, rem, cnt, peff_in, mag;
  logic [dw:0] delta, ndelta, inc, ramp;
  // distance to the new sample, its magnitude, and the next ramp value
  always_comb begin
    delta = {sample_in[dw-1], sample_in} - {sample_out[dw-1], sample_out};
    ndelta = -delta;
    mag = delta[dw] ? ndelta[dw-1:0] : delta[dw-1:0];
    peff_in = period == '0 ? dw'(1) : period;
    inc = {1'b0, step} + {{dw{1'b0}}, extra};
    ramp = neg ? {sample_out[dw-1], sample_out} - inc : {sample_out[dw-1], sample_out} + inc;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else if (cen) state <= next;
  // a new sample restarts from any state; the divider result is taken once it goes idle
  always_comb begin
    next = sample_stb ? START :
           state == START ? SKIP :
           state == SKIP ? WAIT :
           state == WAIT ? (div_working ? WAIT : RUN) :
           state == RUN ? (cnt == dw'(1) ? IDLE : RUN) : IDLE;
    div_start = state == START;
    busy = state != IDLE;
  end
  // sample capture, divider operands, quotient latch and ramp stepping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sample_out <= '0;
      neg <= 1'b0;
      div_a <= '0;
      div_b <= '0;
      peff <= '0;
      step <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (cen) begin
      if (sample_stb) begin
        neg <= delta[dw];
        div_a <= mag;
        div_b <= peff_in;
        peff <= peff_in;
      end else if (state == WAIT && !div_working) begin
        step <= div_d;
        rem <= div_r;
        cnt <= peff;
      end else if (state == RUN) begin
        sample_out <= ramp[dw-1:0];
        cnt <= cnt - dw'(1);
      end
    end
  jt10_adpcmb_erracc #(.dw(dw)) u_erracc (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .rem  (rem),
    .peff (peff),
    .clr  (sample_stb),
    .adv  (state == RUN),
    .extra(extra)
  );
`else
  logic unused;
  assign unused = ^{period, div_d, div_r, div_working};
  assign div_start = 1'b0;
  assign div_a = '0;
  assign div_b = '0;
  assign busy = 1'b0;
  // zero-order hold of each accepted sample
  always_ff @(posedge clk or posedge rst)
    if (rst) sample_out <= '0;
    else if (cen && sample_stb) sample_out <= sample_in;
`endif
endmodule

// File: tb/tb_jt10_adpcmb_interp.sv
// tb_jt10_adpcmb_interp: scoreboard bench; hold behaviour by default, ramps with JT10_ADPCMB_INTERP_EN
module tb_jt10_adpcmb_interp;
  localparam int dw = 16;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b0, sample_stb = 1'b0, div_working = 1'b0;
  logic [dw-1:0] sample_in = '0, period = '0, div_d = '0, div_r = '0;
  logic [dw-1:0] div_a, div_b, sample_out;
  logic div_start, busy;
  int n_chk = 0, n_fail = 0, cyc = 0, n_start = 0, mval = 0;
  typedef struct { int val; int at; } exp_t;
  exp_t sb[$];

  jt10_adpcmb_interp #(.dw(dw)) dut (
    .clk(clk), .rst(rst), .cen(cen), .sample_in(sample_in), .sample_stb(sample_stb),
    .period(period), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_d(div_d), .div_r(div_r), .div_working(div_working),
    .sample_out(sample_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (cen && div_start) n_start <= n_start + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every change of sample_out must match the next queued value at its cycle
  int prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev = int'($signed(sample_out));
    else begin
      if (int'($signed(sample_out)) != prev) begin
        if (sb.size() == 0) chk("unexpected_change", int'($signed(sample_out)), prev);
        else begin
          e = sb.pop_front();
          chk("sample_out", int'($signed(sample_out)), e.val);
          chk("sample_time", cyc, e.at);
        end
        prev = int'($signed(sample_out));
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        chk("missed_sample", prev, e.val);
      end
`ifndef JT10_ADPCMB_INTERP_EN
      chk("div_start_idle", int'(div_start), 0);
      chk("busy_idle", int'(busy), 0);
      chk("div_a_idle", int'(div_a), 0);
      chk("div_b_idle", int'(div_b), 0);
`endif
    end
  end

`ifdef JT10_ADPCMB_INTERP_EN
  // serial divider stand-in: busy for dw cen after the strobe is seen, never reset
  int dcnt = 0;
  always @(posedge clk)
    if (cen) begin
      if (div_start) begin
        div_working <= 1'b1;
        dcnt <= dw;
        div_d <= div_a / div_b;
        div_r <= div_a % div_b;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        div_working <= dcnt > 1;
      end
    end

  // reference ramp: value after tick k is x0 + floor(k*|x1-x0|/p) toward x1
  int r_x0 = 0, r_x1 = 0, r_p = 1, r_s = 0;
  function automatic int ramp_at(input int c);
    longint k, a;
    if (c < r_s + dw + 3) return r_x0;
    k = c - (r_s + dw + 2);
    if (k > r_p) k = r_p;
    a = r_x1 - r_x0;
    return int'(r_x0 + (a < 0 ? -((-a) * k / r_p) : a * k / r_p));
  endfunction

  task automatic issue(input int v, input int p);
    int x0, last, val;
    @(negedge clk);
    x0 = ramp_at(cyc);
    while (sb.size() != 0 && sb[$].at >= cyc + 1) void'(sb.pop_back());
    r_x0 = x0; r_x1 = v; r_p = p == 0 ? 1 : p; r_s = cyc + 1;
    sample_stb = 1'b1; sample_in = dw'(v); period = dw'(p);
    last = x0;
    for (int k = 1; k <= r_p; k++) begin
      val = ramp_at(r_s + dw + 2 + k);
      if (val != last) sb.push_back('{val, r_s + dw + 2 + k});
      last = val;
    end
    @(negedge clk);
    sample_stb = 1'b0;
    chk("div_a", int'(div_a), v > x0 ? v - x0 : x0 - v);
    chk("div_b", int'(div_b), r_p);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("idle_timeout", int'(busy), 0);
    chk("final_value", int'($signed(sample_out)), r_x1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int s0;
    cen = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(sample_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_div_start", int'(div_start), 0);
    @(posedge clk) #2 rst = 1'b0;
    issue(100, 8); wait_idle();
    issue(-100, 3); wait_idle();
    issue(0, 4); wait_idle();
    issue(500, 0); wait_idle();
    issue(0, 2); wait_idle();
    s0 = n_start;
    issue(100, 8);
    wait_cyc(r_s + dw + 5);
    chk("ramp_tick3", int'($signed(sample_out)), 37);
    issue(37, 8); wait_idle();
    chk("restart_strobes", n_start - s0, 2);
    issue(200, 4);
    wait_cyc(r_s + dw + 5);
    issue(-50, 5); wait_idle();
    issue(300, 6);
    wait_cyc(r_s + 6);
    @(posedge clk) #2 rst = 1'b1;
    #1;
    chk("async_out", int'(sample_out), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_div_a", int'(div_a), 0);
    chk("async_div_b", int'(div_b), 0);
    chk("async_div_start", int'(div_start), 0);
    sb.delete();
    r_x0 = 0; r_x1 = 0; r_p = 1; r_s = 0;
    @(posedge clk) #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_reset_hold", int'(sample_out), 0);
    for (int n = 0; n < 8; n++) begin
      issue(int'($signed(dw'($urandom))), int'($urandom_range(0, 20)));
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
`else
  task automatic drive(input logic c, input logic s, input logic [dw-1:0] v);
    @(negedge clk);
    cen = c; sample_stb = s; sample_in = v;
    if (c && s && int'($signed(v)) != mval) begin
      mval = int'($signed(v));
      sb.push_back('{mval, cyc + 1});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", int'(sample_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_div_start", int'(div_start), 0);
    @(posedge clk) #2 rst = 1'b0;
    drive(1'b1, 1'b1, 16'h7FFF);
    drive(1'b1, 1'b1, 16'h8000);
    drive(1'b0, 1'b1, 16'h0123);
    drive(1'b1, 1'b0, 16'h0456);
    for (int n = 0; n < 300; n++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), dw'($urandom));
    drive(1'b1, 1'b1, 16'h1234);
    drive(1'b0, 1'b0, 16'h0000);
    @(posedge clk) #2 rst = 1'b1;
    #1;
    chk("async_out", int'(sample_out), 0);
    sb.delete();
    mval = 0;
    @(posedge clk) #2 rst = 1'b0;
    for (int n = 0; n < 200; n++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), dw'($urandom));
    repeat (3) drive(1'b1, 1'b0, 16'h0000);
    chk("final_value", int'($signed(sample_out)), mval);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
`endif
endmodule
